// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, colour, octant and FSM state types
package vga_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef logic [2:0]        colour_t;
   typedef logic [2:0]        octant_t;
   typedef logic signed [9:0] coord_t;
   typedef logic signed [10:0] crit_t;

   typedef enum logic [1:0] {IDLE, INIT, PLOT, DONE} state_t;
endpackage

// File: rtl/arc_point_gen.sv
// rtl/arc_point_gen.sv - maps centre/offsets/octant to a candidate pixel and its plot qualifier
module arc_point_gen
   import vga_pkg::*;
(
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  coord_t     ox,
   input  coord_t     oy,
   input  octant_t    k,
   input  logic [7:0] octant_mask,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       plot_ok
);
   coord_t cx, cy, px, py;

   assign cx = $signed({2'b00, centre_x});
   assign cy = $signed({3'b000, centre_y});

   always_comb begin
      px = cx + ox;
      py = cy + oy;
      case (k)
         3'd0: begin px = cx + ox; py = cy + oy; end
         3'd1: begin px = cx + oy; py = cy + ox; end
         3'd2: begin px = cx - oy; py = cy + ox; end
         3'd3: begin px = cx - ox; py = cy + oy; end
         3'd4: begin px = cx - ox; py = cy - oy; end
         3'd5: begin px = cx - oy; py = cy - ox; end
         3'd6: begin px = cx + oy; py = cy - ox; end
         default: begin px = cx + ox; py = cy - oy; end
      endcase
   end

   // Bounds are checked on the full signed value so negative or oversize coordinates never wrap on screen.
   assign plot_ok = octant_mask[k] && !px[9] && (px < coord_t'(SCREEN_W))
                                   && !py[9] && (py < coord_t'(SCREEN_H));
   assign x = px[7:0];
   assign y = py[6:0];
endmodule

// File: rtl/arc_plotter.sv
// rtl/arc_plotter.sv - midpoint circle engine emitting one octant-masked candidate pixel per clock
module arc_plotter
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  colour_t    colour,
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  logic [7:0] radius,
   input  logic [7:0] octant_mask,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output colour_t    vga_colour,
   output logic       vga_plot
);
   state_t     state, state_next;
   colour_t    col_r;
   logic [7:0] cx_r, rad_r, mask_r;
   logic [6:0] cy_r;
   coord_t     ox, oy, ox_n, oy_n;
   crit_t      crit, crit_n, ox_w, oy_w;
   octant_t    k;
   logic       crit_le0, last_iter;
   logic [7:0] gen_x;
   logic [6:0] gen_y;
   logic       gen_ok;

   arc_point_gen u_point_gen (
      .centre_x    (cx_r),
      .centre_y    (cy_r),
      .ox          (ox),
      .oy          (oy),
      .k           (k),
      .octant_mask (mask_r),
      .x           (gen_x),
      .y           (gen_y),
      .plot_ok     (gen_ok)
   );

   // Midpoint step, applied only after the last octant of each iteration.
   assign crit_le0  = crit[10] || (crit == '0);
   assign oy_n      = oy + 10'sd1;
   assign ox_n      = crit_le0 ? ox : ox - 10'sd1;
   assign oy_w      = $signed({oy_n[9], oy_n});
   assign ox_w      = $signed({ox_n[9], ox_n});
   assign crit_n    = crit_le0 ? crit + (oy_w <<< 1) + 11'sd1
                               : crit + ((oy_w - ox_w) <<< 1) + 11'sd1;
   assign last_iter = oy_n > ox_n;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = INIT;
         INIT: state_next = PLOT;
         PLOT: if (k == 3'd7 && last_iter) state_next = DONE;
         DONE: if (!start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         done       <= 1'b0;
         vga_plot   <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         col_r      <= '0;
         cx_r       <= '0;
         cy_r       <= '0;
         rad_r      <= '0;
         mask_r     <= '0;
         ox         <= '0;
         oy         <= '0;
         crit       <= '0;
         k          <= '0;
      end else begin
         state    <= state_next;
         done     <= (state == DONE) && start;
         vga_plot <= (state == PLOT) && gen_ok;
         case (state)
            IDLE: if (start) begin
               col_r  <= colour;
               cx_r   <= centre_x;
               cy_r   <= centre_y;
               rad_r  <= radius;
               mask_r <= octant_mask;
            end
            INIT: begin
               ox   <= $signed({2'b00, rad_r});
               oy   <= '0;
               crit <= 11'sd1 - $signed({3'b000, rad_r});
               k    <= '0;
            end
            PLOT: begin
               vga_x      <= gen_x;
               vga_y      <= gen_y;
               vga_colour <= col_r;
               k          <= k + 3'd1;
               if (k == 3'd7) begin
                  ox   <= ox_n;
                  oy   <= oy_n;
                  crit <= crit_n;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_arc_plotter.sv
// tb/tb_arc_plotter.sv - scoreboard bench for arc_plotter
module tb_arc_plotter;
   import vga_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start;
   colour_t    colour;
   logic [7:0] centre_x, radius, octant_mask;
   logic [6:0] centre_y;
   logic       done, vga_plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   colour_t    vga_colour;

   arc_plotter dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .colour      (colour),
      .centre_x    (centre_x),
      .centre_y    (centre_y),
      .radius      (radius),
      .octant_mask (octant_mask),
      .done        (done),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   n, cyc, first;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   // Reference midpoint circle: pushes every on-screen, enabled pixel; returns iteration count.
   function automatic int model(input int cx, input int cy, input int r,
                                input logic [7:0] m, input logic [2:0] c);
      int ox, oy, crit, iters, px, py;
      ox = r; oy = 0; crit = 1 - r; iters = 0;
      do begin
         iters++;
         for (int kk = 0; kk < 8; kk++) begin
            case (kk)
               0: begin px = cx + ox; py = cy + oy; end
               1: begin px = cx + oy; py = cy + ox; end
               2: begin px = cx - oy; py = cy + ox; end
               3: begin px = cx - ox; py = cy + oy; end
               4: begin px = cx - ox; py = cy - oy; end
               5: begin px = cx - oy; py = cy - ox; end
               6: begin px = cx + oy; py = cy - ox; end
               default: begin px = cx + ox; py = cy - oy; end
            endcase
            if (m[kk] && px >= 0 && px < 160 && py >= 0 && py < 120)
               exp_q.push_back('{x: px[7:0], y: py[6:0], c: c});
         end
         oy++;
         if (crit <= 0) crit += 2 * oy + 1;
         else begin
            ox--;
            crit += 2 * (oy - ox) + 1;
         end
      end while (oy <= ox);
      return iters;
   endfunction

   always @(negedge clk) begin
      pix_t e;
      if (!rst && vga_plot) begin
         if (exp_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("pix_x", 32'(vga_x), 32'(e.x));
            check("pix_y", 32'(vga_y), 32'(e.y));
            check("pix_colour", 32'(vga_colour), 32'(e.c));
         end
         check("plot_done_overlap", 32'(done), 32'd0);
      end
   end

   task automatic wait_done(input int budget, output int cycles, output int first_pulse);
      cycles = 0;
      first_pulse = -1;
      while (cycles < budget) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (vga_plot && first_pulse < 0) first_pulse = cycles;
         if (done) break;
      end
   endtask

   task automatic draw(input int cx, input int cy, input int r, input logic [7:0] m,
                       input logic [2:0] c, input string tag);
      int iters, cycles, fp;
      iters = model(cx, cy, r, m, c);
      centre_x    = cx[7:0];
      centre_y    = cy[6:0];
      radius      = r[7:0];
      octant_mask = m;
      colour      = c;
      start       = 1'b1;
      @(posedge clk);
      #1;
      centre_x    = ~centre_x;
      centre_y    = ~centre_y;
      radius      = radius ^ 8'h5A;
      octant_mask = ~m;
      colour      = ~c;
      wait_done(8 * 260 + 10, cycles, fp);
      check({tag, "_cycles"}, 32'(cycles), 32'(8 * iters + 2));
      check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd1);
      exp_q.delete();
   endtask

   task automatic release_start(input string tag);
      start = 1'b0;
      @(negedge clk);
      check({tag, "_done_low"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; colour = '0;
      centre_x = '0; centre_y = '0; radius = '0; octant_mask = '0;
      repeat (3) @(negedge clk);
      check("rst_plot", 32'(vga_plot), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_x", 32'(vga_x), 32'd0);
      check("rst_y", 32'(vga_y), 32'd0);
      check("rst_colour", 32'(vga_colour), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      draw(80, 60, 0, 8'hFF, 3'b010, "r0");
      release_start("r0");
      draw(10, 10, 1, 8'hFF, 3'b101, "r1");
      release_start("r1");
      draw(0, 0, 5, 8'hFF, 3'b110, "corner_lo");
      release_start("corner_lo");
      draw(159, 119, 5, 8'hFF, 3'b011, "corner_hi");
      release_start("corner_hi");
      draw(80, 60, 10, 8'h01, 3'b111, "mask01");
      release_start("mask01");
      draw(120, 20, 37, 8'b1010_0110, 3'b001, "mask_mix");
      release_start("mask_mix");

      draw(40, 50, 7, 8'hFF, 3'b011, "hs1");
      repeat (20) @(negedge clk);
      check("hold_done", 32'(done), 32'd1);
      release_start("hs1");
      draw(40, 50, 7, 8'hFF, 3'b011, "hs2");
      release_start("hs2");

      n = model(80, 60, 30, 8'hFF, 3'b100);
      centre_x = 8'd80; centre_y = 7'd60; radius = 8'd30;
      octant_mask = 8'hFF; colour = 3'b100; start = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_plot", 32'(vga_plot), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      exp_q.delete();
      n = model(80, 60, 30, 8'hFF, 3'b100);
      rst = 1'b0;
      @(posedge clk);
      #1;
      wait_done(8 * 260 + 10, cyc, first);
      check("restart_first", 32'(first), 32'd2);
      check("restart_cycles", 32'(cyc), 32'(8 * n + 2));
      check("restart_left", 32'(exp_q.size()), 32'd0);
      release_start("restart");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
